// File: rtl/alu_mdu_seq_if.sv
// Request/result bundle for the alu_mdu_seq execute unit.
// Signal names follow the unit's own port naming (_i into the unit,
// _o out of the unit), so the slave modport is the unit itself.
//   flush_i            kill in-flight/held op
//   valid_i / ready_o  request handshake, operands A_i/B_i, opcode aluc_i
//   valid_o / ready_i  result handshake, result C_o, branch_o, illegal_o
interface alu_mdu_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush_i;
    logic            valid_i;
    logic            ready_o;
    logic [XLEN-1:0] A_i;
    logic [XLEN-1:0] B_i;
    logic [4:0]      aluc_i;
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] C_o;
    logic            branch_o;
    logic            illegal_o;

    modport master (
        output flush_i, valid_i, A_i, B_i, aluc_i, ready_i,
        input  ready_o, valid_o, C_o, branch_o, illegal_o
    );

    modport slave (
        input  flush_i, valid_i, A_i, B_i, aluc_i, ready_i,
        output ready_o, valid_o, C_o, branch_o, illegal_o
    );
endinterface

// File: rtl/alu_mdu_seq.sv
// Execute unit: registered single-cycle ALU / branch compare plus iterative
// RV M-extension multiply (shift-add) and divide (restoring), 1 bit/cycle.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-high reset
//   bus_io  alu_mdu_seq_if.slave: request (valid_i/ready_o, A_i, B_i,
//           aluc_i), result (valid_o/ready_i, C_o, branch_o, illegal_o),
//           flush_i
module alu_mdu_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    alu_mdu_seq_if.slave bus_io
);
    localparam int unsigned SHAMT_W = $clog2(XLEN);
    localparam int unsigned CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;   // MUL: {hi, lo/multiplier}; DIV: {rem, dividend/quotient}
    logic [XLEN-1:0]   opd_q, opd_d;   // MUL: |multiplicand|; DIV: |divisor|
    logic              neg_q, neg_d;   // negate final result
    logic              hi_q, hi_d;     // select upper half (MULH*, REM*)
    logic [XLEN-1:0]   c_q, c_d;
    logic              br_q, br_d;
    logic              ill_q, ill_d;

    logic [XLEN-1:0]    a, b;
    logic [4:0]         aluc;
    logic [SHAMT_W-1:0] shamt;
    logic               ready, accept;

    assign a      = bus_io.A_i;
    assign b      = bus_io.B_i;
    assign aluc   = bus_io.aluc_i;
    assign shamt  = b[SHAMT_W-1:0];
    assign ready  = ((state_q == IDLE) | ((state_q == DONE) & bus_io.ready_i))
                    & ~bus_io.flush_i & ~rst_i;
    assign accept = bus_io.valid_i & ready;

    // Single-cycle ALU and branch compare
    logic [XLEN-1:0] alu_c;
    logic            alu_br;

    always_comb begin
        alu_c  = '0;
        alu_br = 1'b0;
        case (aluc)
            5'd0:  alu_c = a + b;
            5'd1:  alu_c = a - b;
            5'd2:  alu_c = a << shamt;
            5'd3:  alu_c = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            5'd4:  alu_c = {{(XLEN-1){1'b0}}, a < b};
            5'd5:  alu_c = a ^ b;
            5'd6:  alu_c = a >> shamt;
            5'd7:  alu_c = $signed(a) >>> shamt;
            5'd8:  alu_c = a | b;
            5'd9:  alu_c = a & b;
            5'd10: alu_br = (a == b);
            5'd11: alu_br = (a != b);
            5'd12: alu_br = $signed(a) < $signed(b);
            5'd13: alu_br = $signed(a) >= $signed(b);
            5'd14: alu_br = a < b;
            5'd15: alu_br = a >= b;
            default: ;
        endcase
    end

    // Decode of a newly accepted op: either a finished result (ALU, branch,
    // illegal, divide special case) or the initial iteration state.
    logic              a_neg, b_neg, div_sgn, div_rem;
    logic [XLEN-1:0]   mag_a, mag_b;
    state_e            st_state;
    logic [XLEN-1:0]   st_c, st_opd;
    logic              st_br, st_ill, st_neg, st_hi;
    logic [2*XLEN-1:0] st_acc;

    always_comb begin
        div_sgn = ~aluc[0];
        div_rem = aluc[1];
        a_neg   = 1'b0;
        b_neg   = 1'b0;
        if (aluc[4:3] == 2'b10) begin
            if (!aluc[2]) begin
                a_neg = (aluc[1:0] != 2'b11) & a[XLEN-1];
                b_neg = ~aluc[1] & b[XLEN-1];
            end else begin
                a_neg = div_sgn & a[XLEN-1];
                b_neg = div_sgn & b[XLEN-1];
            end
        end
        mag_a = a_neg ? -a : a;
        mag_b = b_neg ? -b : b;

        st_state = DONE;
        st_c     = '0;
        st_br    = 1'b0;
        st_ill   = 1'b0;
        st_opd   = '0;
        st_acc   = '0;
        st_neg   = 1'b0;
        st_hi    = 1'b0;
        if (!aluc[4]) begin
            st_c  = alu_c;
            st_br = alu_br;
        end else if (aluc[3]) begin
            st_ill = 1'b1;
        end else if (!aluc[2]) begin
            st_state = MUL;
            st_opd   = mag_a;
            st_acc   = {{XLEN{1'b0}}, mag_b};
            st_neg   = a_neg ^ b_neg;
            st_hi    = (aluc[1:0] != 2'b00);
        end else if (b == '0) begin
            st_c = div_rem ? a : '1;
        end else if (div_sgn && (a == MIN_NEG) && (b == '1)) begin
            st_c = div_rem ? '0 : MIN_NEG;
        end else begin
            st_state = DIV;
            st_opd   = mag_b;
            st_acc   = {{XLEN{1'b0}}, mag_a};
            // remainder follows the dividend's sign, quotient the sign product
            st_neg   = div_rem ? a_neg : (a_neg ^ b_neg);
            st_hi    = div_rem;
        end
    end

    // One multiply step: conditionally add multiplicand to the upper half,
    // then shift the whole product right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, prod_fin;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    assign prod_fin = neg_q ? -mul_next : mul_next;

    // One restoring divide step on {rem, dividend}; the trial difference
    // borrow bit decides the quotient bit shifted into the low end.
    logic [XLEN:0]     div_shift, div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   div_sel, div_fin;

    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opd_q};
    assign div_next  = div_diff[XLEN]
                     ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                     : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    assign div_sel   = hi_q ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    assign div_fin   = neg_q ? -div_sel : div_sel;

    // The final iteration and the sign fix-up share a cycle so that
    // MUL/DIV results appear XLEN+1 cycles after accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opd_d   = opd_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        c_d     = c_q;
        br_d    = br_q;
        ill_d   = ill_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = st_state;
                    cnt_d   = '0;
                    acc_d   = st_acc;
                    opd_d   = st_opd;
                    neg_d   = st_neg;
                    hi_d    = st_hi;
                    if (st_state == DONE) begin
                        c_d   = st_c;
                        br_d  = st_br;
                        ill_d = st_ill;
                    end
                end else if (state_q == DONE && bus_io.ready_i) begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = DONE;
                    c_d     = hi_q ? prod_fin[2*XLEN-1:XLEN] : prod_fin[XLEN-1:0];
                    br_d    = 1'b0;
                    ill_d   = 1'b0;
                end
            end
            DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    state_d = DONE;
                    c_d     = div_fin;
                    br_d    = 1'b0;
                    ill_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus_io.flush_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opd_q   <= '0;
            neg_q   <= 1'b0;
            hi_q    <= 1'b0;
            c_q     <= '0;
            br_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            c_q     <= c_d;
            br_q    <= br_d;
            ill_q   <= ill_d;
        end
    end

    assign bus_io.ready_o   = ready;
    assign bus_io.valid_o   = (state_q == DONE);
    assign bus_io.C_o       = c_q;
    assign bus_io.branch_o  = br_q;
    assign bus_io.illegal_o = ill_q;
endmodule
